// File: rtl/spi_pkg.sv
// Shared definitions for the SPI sensor poller.
//   spi_state_e       : transaction FSM states (IDLE -> SETUP -> SHIFT -> HOLD -> GUARD)
//   ADXL_*            : ADXL362 command bytes and register addresses
//   spi_nbits()       : total bits shifted per burst (command + address + axis data)
//   spi_cs_low_cycles : system clocks chip select is held low for one burst
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GUARD
  } spi_state_e;

  localparam logic [7:0] ADXL_READ_CMD  = 8'h0B;
  localparam logic [7:0] ADXL_WRITE_CMD = 8'h0A;
  localparam logic [7:0] ADXL_XDATA_L   = 8'h0E;
  localparam logic [7:0] ADXL_POWER_CTL = 8'h2D;

  function automatic int spi_nbits(input int num_axes, input int axis_bits);
    return 16 + num_axes * axis_bits;
  endfunction

  function automatic int spi_cs_low_cycles(input int clk_div, input int nbits);
    return clk_div * (2 + 2 * nbits);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator running on the system clock.
//   clock, reset : system clock, async active-high reset
//   en           : counter runs while high; held cleared otherwise
//   run_sclk     : when high, sclk toggles every half period; when low sclk stays 0
//   half_tick    : last cycle of each CLK_DIV-cycle half period
//   rise_tick    : cycle at whose end sclk goes high
//   fall_tick    : cycle at whose end sclk goes low
//   sclk         : registered SPI clock, mode 0 (idles low)
module spi_clk_div #(
  parameter int CLK_DIV = 12
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic run_sclk,
  output logic half_tick,
  output logic rise_tick,
  output logic fall_tick,
  output logic sclk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          phase;

  assign half_tick = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = half_tick && run_sclk && !phase;
  assign fall_tick = half_tick && run_sclk && phase;
  assign sclk      = phase;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (half_tick) begin
      cnt <= '0;
      if (run_sclk) phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_sensor_poller.sv
// Autonomous SPI master that burst-reads NUM_AXES axes from an ADXL362-class
// sensor and publishes an atomic snapshot.
//   clock, reset      : system clock, async active-high reset
//   enable            : periodic triggering every SAMPLE_PERIOD clocks
//   sample_req        : single-cycle on-demand trigger
//   clear_overrun     : clears the sticky overrun flag
//   miso/sclk/mosi/cs_n : SPI mode 0 bus
//   busy              : transaction in progress (SETUP through GUARD)
//   sample_valid      : one-cycle pulse when the snapshot updates
//   axis_sel/axis_data: combinational snapshot read port (0 for unused indices)
//   packed_out        : top OUT_BITS of each axis, axis 0 in the top field
//   overrun           : sticky, a trigger was dropped because busy was high
module spi_sensor_poller
  import spi_pkg::*;
#(
  parameter int          CLK_DIV       = 12,
  parameter int          NUM_AXES      = 3,
  parameter int          AXIS_BITS     = 16,
  parameter int          OUT_BITS      = 5,
  parameter int          SAMPLE_PERIOD = 100000,
  parameter logic [7:0]  READ_CMD      = ADXL_READ_CMD,
  parameter logic [7:0]  START_ADDR    = ADXL_XDATA_L
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         sample_req,
  input  logic                         clear_overrun,
  input  logic                         miso,
  output logic                         sclk,
  output logic                         mosi,
  output logic                         cs_n,
  output logic                         busy,
  output logic                         sample_valid,
  input  logic [2:0]                   axis_sel,
  output logic [AXIS_BITS-1:0]         axis_data,
  output logic [NUM_AXES*OUT_BITS-1:0] packed_out,
  output logic                         overrun
);

  localparam int NBITS      = spi_nbits(NUM_AXES, AXIS_BITS);
  localparam int DATA_BITS  = NUM_AXES * AXIS_BITS;
  localparam int AXIS_BYTES = AXIS_BITS / 8;
  localparam int BCW        = $clog2(NBITS);
  localparam int PCW        = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  spi_state_e state, state_nxt;

  logic                 div_en, run_sclk;
  logic                 half_tick, rise_tick, fall_tick;
  logic [PCW-1:0]       per_cnt;
  logic                 per_trig, trigger;
  logic [BCW-1:0]       bit_cnt;
  logic [15:0]          tx_sr;
  logic [DATA_BITS-1:0] rx_sr;
  logic [AXIS_BITS-1:0] rx_axes [NUM_AXES];
  logic [AXIS_BITS-1:0] snap    [NUM_AXES];

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clock     (clock),
    .reset     (reset),
    .en        (div_en),
    .run_sclk  (run_sclk),
    .half_tick (half_tick),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .sclk      (sclk)
  );

  // Trigger generation: periodic counter plus on-demand request, merged.
  assign per_trig = enable && (per_cnt == PCW'(SAMPLE_PERIOD - 1));
  assign trigger  = sample_req || per_trig;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      per_cnt <= '0;
    end else if (!enable || per_trig) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // A drop while busy sets the flag even if clear_overrun is asserted too.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (trigger && busy) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end

  // Transaction FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cs_n      = 1'b1;
    busy      = 1'b0;
    div_en    = 1'b0;
    run_sclk  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (trigger) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        cs_n   = 1'b0;
        busy   = 1'b1;
        div_en = 1'b1;
        if (half_tick) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        cs_n     = 1'b0;
        busy     = 1'b1;
        div_en   = 1'b1;
        run_sclk = 1'b1;
        if (fall_tick && (bit_cnt == BCW'(NBITS - 1))) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        cs_n   = 1'b0;
        busy   = 1'b1;
        div_en = 1'b1;
        if (half_tick) state_nxt = ST_GUARD;
      end
      ST_GUARD: begin
        busy   = 1'b1;
        div_en = 1'b1;
        if (half_tick) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shift datapath: mosi moves on sclk fall, miso is captured on sclk rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      tx_sr   <= '0;
    end else begin
      if (state == ST_IDLE && trigger) begin
        tx_sr <= {READ_CMD, START_ADDR};
      end else if (fall_tick) begin
        tx_sr <= {tx_sr[14:0], 1'b0};
      end
      if (fall_tick) begin
        bit_cnt <= (bit_cnt == BCW'(NBITS - 1)) ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  assign mosi = tx_sr[15];

  // Command and address bits fall off the top; only axis data remains.
  always_ff @(posedge clock) begin
    if (rise_tick) rx_sr <= {rx_sr[DATA_BITS-2:0], miso};
  end

  // Byte i of the burst sits at the i-th byte from the top of rx_sr; each
  // axis is little-endian, lowest-addressed byte least significant.
  always_comb begin
    for (int k = 0; k < NUM_AXES; k++) begin
      rx_axes[k] = '0;
      for (int j = 0; j < AXIS_BYTES; j++) begin
        rx_axes[k][j*8 +: 8] =
          rx_sr[(NUM_AXES*AXIS_BYTES - 1 - (k*AXIS_BYTES + j))*8 +: 8];
      end
    end
  end

  // Snapshot commit: only on the HOLD -> GUARD edge so readers never see a
  // partially received burst.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_valid <= 1'b0;
      for (int k = 0; k < NUM_AXES; k++) snap[k] <= '0;
    end else begin
      sample_valid <= (state == ST_HOLD) && half_tick;
      if ((state == ST_HOLD) && half_tick) snap <= rx_axes;
    end
  end

  // Read ports.
  always_comb begin
    axis_data = '0;
    for (int k = 0; k < NUM_AXES; k++) begin
      if (int'(axis_sel) == k) axis_data = snap[k];
    end
  end

  always_comb begin
    packed_out = '0;
    for (int k = 0; k < NUM_AXES; k++) begin
      packed_out[(NUM_AXES-1-k)*OUT_BITS +: OUT_BITS] = snap[k][AXIS_BITS-1 -: OUT_BITS];
    end
  end

endmodule

// File: tb/tb_spi_sensor_poller.sv
// Self-checking bench for spi_sensor_poller: a default-geometry instance (A)
// with a short sample period and a 1-axis, 8-bit, CLK_DIV=2 instance (B),
// each driven by a small behavioural sensor model.
module tb_spi_sensor_poller;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Instance A: defaults, SAMPLE_PERIOD shortened to 5000.
  logic        enable_a, sample_req_a, clear_overrun_a, miso_a;
  logic        sclk_a, mosi_a, cs_n_a, busy_a, sample_valid_a, overrun_a;
  logic [2:0]  axis_sel_a;
  logic [15:0] axis_data_a;
  logic [14:0] packed_out_a;

  spi_sensor_poller #(.SAMPLE_PERIOD(5000)) dut_a (
    .clock(clock), .reset(reset), .enable(enable_a), .sample_req(sample_req_a),
    .clear_overrun(clear_overrun_a), .miso(miso_a), .sclk(sclk_a), .mosi(mosi_a),
    .cs_n(cs_n_a), .busy(busy_a), .sample_valid(sample_valid_a),
    .axis_sel(axis_sel_a), .axis_data(axis_data_a), .packed_out(packed_out_a),
    .overrun(overrun_a)
  );

  // Instance B: parameter sweep geometry.
  logic        enable_b, sample_req_b, clear_overrun_b, miso_b;
  logic        sclk_b, mosi_b, cs_n_b, busy_b, sample_valid_b, overrun_b;
  logic [2:0]  axis_sel_b;
  logic [7:0]  axis_data_b;
  logic [4:0]  packed_out_b;

  spi_sensor_poller #(.CLK_DIV(2), .NUM_AXES(1), .AXIS_BITS(8), .SAMPLE_PERIOD(1000)) dut_b (
    .clock(clock), .reset(reset), .enable(enable_b), .sample_req(sample_req_b),
    .clear_overrun(clear_overrun_b), .miso(miso_b), .sclk(sclk_b), .mosi(mosi_b),
    .cs_n(cs_n_b), .busy(busy_b), .sample_valid(sample_valid_b),
    .axis_sel(axis_sel_b), .axis_data(axis_data_b), .packed_out(packed_out_b),
    .overrun(overrun_b)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Sensor model A: presents frame bit idx on miso, advancing after each
  // sclk fall; also records the first 16 bits seen on mosi at sclk rises.
  logic [63:0] frame_a;
  int          idx_a = 0, rcnt_a = 0;
  logic        sclk_q_a = 1'b0;
  logic [15:0] cmd_a;
  always @(posedge clock) begin
    sclk_q_a <= sclk_a;
    if (cs_n_a) begin
      idx_a  <= 0;
      rcnt_a <= 0;
    end else begin
      if (sclk_q_a && !sclk_a) idx_a <= idx_a + 1;
      if (!sclk_q_a && sclk_a && rcnt_a < 16) begin
        cmd_a[15-rcnt_a] <= mosi_a;
        rcnt_a <= rcnt_a + 1;
      end
    end
  end
  assign miso_a = (!cs_n_a && idx_a < 64) ? frame_a[63-idx_a] : 1'b0;

  logic [23:0] frame_b;
  int          idx_b = 0, rcnt_b = 0;
  logic        sclk_q_b = 1'b0;
  logic [15:0] cmd_b;
  always @(posedge clock) begin
    sclk_q_b <= sclk_b;
    if (cs_n_b) begin
      idx_b  <= 0;
      rcnt_b <= 0;
    end else begin
      if (sclk_q_b && !sclk_b) idx_b <= idx_b + 1;
      if (!sclk_q_b && sclk_b && rcnt_b < 16) begin
        cmd_b[15-rcnt_b] <= mosi_b;
        rcnt_b <= rcnt_b + 1;
      end
    end
  end
  assign miso_b = (!cs_n_b && idx_b < 24) ? frame_b[23-idx_b] : 1'b0;

  // Bus monitors: cs_n low length, cs_n fall times, sample_valid count.
  int   low_a = 0, last_low_a = 0, sv_a = 0;
  int   low_b = 0, last_low_b = 0, sv_b = 0;
  logic cs_q_a = 1'b1;
  int   fall_q[$];
  always @(negedge clock) begin
    cs_q_a <= cs_n_a;
    if (cs_q_a && !cs_n_a) fall_q.push_back(cyc);
    if (!cs_n_a) low_a <= low_a + 1;
    else if (low_a != 0) begin
      last_low_a <= low_a;
      low_a <= 0;
    end
    if (sample_valid_a) sv_a <= sv_a + 1;
    if (!cs_n_b) low_b <= low_b + 1;
    else if (low_b != 0) begin
      last_low_b <= low_b;
      low_b <= 0;
    end
    if (sample_valid_b) sv_b <= sv_b + 1;
  end

  typedef struct packed {
    logic [47:0] bytes;
    logic [15:0] ax0;
    logic [15:0] ax1;
    logic [15:0] ax2;
    logic [14:0] pk;
  } vec_t;

  vec_t tbl[4];
  vec_t sb_q[$];

  task automatic pulse_req_a();
    @(negedge clock) sample_req_a = 1'b1;
    @(negedge clock) sample_req_a = 1'b0;
  endtask

  task automatic wait_sv_a(input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clock);
      if (sample_valid_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle_a(input int bound, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clock);
      if (!busy_a) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
    @(negedge clock);
  endtask

  initial begin
    vec_t        e;
    int          sv0, nf;
    bit          ok;
    logic [15:0] exp_ax;

    tbl[0] = '{bytes: 48'h34_12_78_56_BC_9A, ax0: 16'h1234, ax1: 16'h5678,
               ax2: 16'h9ABC, pk: 15'b00010_01010_10011};
    tbl[1] = '{bytes: 48'h00_00_00_00_00_00, ax0: 16'h0000, ax1: 16'h0000,
               ax2: 16'h0000, pk: 15'b00000_00000_00000};
    tbl[2] = '{bytes: 48'hFF_FF_00_00_01_80, ax0: 16'hFFFF, ax1: 16'h0000,
               ax2: 16'h8001, pk: 15'b11111_00000_10000};
    tbl[3] = '{bytes: 48'hCD_AB_00_FF_5A_A5, ax0: 16'hABCD, ax1: 16'hFF00,
               ax2: 16'hA55A, pk: 15'b10101_11111_10100};

    reset = 1'b1;
    enable_a = 0; sample_req_a = 0; clear_overrun_a = 0; axis_sel_a = 0;
    enable_b = 0; sample_req_b = 0; clear_overrun_b = 0; axis_sel_b = 0;
    frame_a = {16'h0, tbl[0].bytes};
    frame_b = {16'h0, 8'hA5};
    repeat (3) @(negedge clock);

    check("rst_cs_n", cs_n_a, 1);
    check("rst_sclk", sclk_a, 0);
    check("rst_mosi", mosi_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_sample_valid", sample_valid_a, 0);
    check("rst_overrun", overrun_a, 0);
    check("rst_packed", packed_out_a, 0);
    check("rst_axis0", axis_data_a, 0);
    reset = 1'b0;

    // Reset in the middle of a burst.
    sv0 = sv_a;
    pulse_req_a();
    repeat (499) @(negedge clock);
    check("midburst_busy", busy_a, 1);
    check("midburst_cs_n", cs_n_a, 0);
    #2 reset = 1'b1;
    #1;
    check("abort_cs_n", cs_n_a, 1);
    check("abort_sclk", sclk_a, 0);
    check("abort_busy", busy_a, 0);
    @(negedge clock) reset = 1'b0;
    repeat (2000) @(negedge clock);
    check("abort_no_valid", sv_a - sv0, 0);
    check("abort_cs_idle", cs_n_a, 1);
    for (int k = 0; k < 3; k++) begin
      axis_sel_a = 3'(k);
      #1 check($sformatf("abort_axis%0d", k), axis_data_a, 0);
    end
    check("abort_packed", packed_out_a, 0);

    // Table-driven single requests through the scoreboard.
    for (int i = 0; i < 4; i++) begin
      frame_a = {16'h0, tbl[i].bytes};
      sb_q.push_back(tbl[i]);
      sv0 = sv_a;
      nf  = fall_q.size();
      pulse_req_a();
      wait_sv_a(3000, ok);
      check($sformatf("v%0d_valid_seen", i), ok, 1);
      e = sb_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        exp_ax = (k == 0) ? e.ax0 : (k == 1) ? e.ax1 : e.ax2;
        axis_sel_a = 3'(k);
        #1 check($sformatf("v%0d_axis%0d", i, k), axis_data_a, exp_ax);
      end
      check($sformatf("v%0d_packed", i), packed_out_a, e.pk);
      wait_idle_a(100, $sformatf("v%0d_idle", i));
      check($sformatf("v%0d_cs_low", i), last_low_a, 1560);
      check($sformatf("v%0d_valid_count", i), sv_a - sv0, 1);
      check($sformatf("v%0d_cs_falls", i), fall_q.size() - nf, 1);
      check($sformatf("v%0d_mosi_cmd", i), cmd_a, 16'h0B0E);
    end

    // Out-of-range axis selects read as zero (snapshot is non-zero here).
    axis_sel_a = 3'd5;
    #1 check("axis_sel5", axis_data_a, 0);
    axis_sel_a = 3'd3;
    #1 check("axis_sel3", axis_data_a, 0);
    axis_sel_a = 3'd0;

    // Overrun: second request during a burst is dropped.
    sv0 = sv_a;
    nf  = fall_q.size();
    check("ovr_before", overrun_a, 0);
    pulse_req_a();
    repeat (99) @(negedge clock);
    pulse_req_a();
    check("ovr_set", overrun_a, 1);
    wait_sv_a(3000, ok);
    check("ovr_valid_seen", ok, 1);
    wait_idle_a(100, "ovr_idle");
    repeat (50) @(negedge clock);
    check("ovr_one_burst", fall_q.size() - nf, 1);
    check("ovr_one_valid", sv_a - sv0, 1);
    check("ovr_sticky", overrun_a, 1);
    @(negedge clock) clear_overrun_a = 1'b1;
    @(negedge clock) clear_overrun_a = 1'b0;
    check("ovr_cleared", overrun_a, 0);

    // New overrun in the same cycle as clear_overrun: the overrun wins.
    pulse_req_a();
    repeat (99) @(negedge clock);
    @(negedge clock) begin
      sample_req_a = 1'b1;
      clear_overrun_a = 1'b1;
    end
    @(negedge clock) begin
      sample_req_a = 1'b0;
      clear_overrun_a = 1'b0;
    end
    check("ovr_beats_clear", overrun_a, 1);
    wait_idle_a(3000, "ovr2_idle");
    @(negedge clock) clear_overrun_a = 1'b1;
    @(negedge clock) clear_overrun_a = 1'b0;
    check("ovr2_cleared", overrun_a, 0);

    // Periodic mode; a request coinciding with the first periodic trigger
    // must not create a second transaction or an overrun.
    sv0 = sv_a;
    nf  = fall_q.size();
    @(posedge clock);
    #1 enable_a = 1'b1;
    repeat (4999) @(posedge clock);
    #1 sample_req_a = 1'b1;
    @(posedge clock);
    #1 sample_req_a = 1'b0;
    repeat (15000) @(posedge clock);
    #1 enable_a = 1'b0;
    check("per_no_overrun", overrun_a, 0);
    repeat (12000) @(negedge clock);
    check("per_bursts", fall_q.size() - nf, 4);
    check("per_valids", sv_a - sv0, 4);
    for (int j = 1; j < 4; j++) begin
      if (nf + j < fall_q.size())
        check($sformatf("per_spacing%0d", j), fall_q[nf+j] - fall_q[nf+j-1], 5000);
      else
        check($sformatf("per_spacing%0d", j), 0, 5000);
    end
    check("per_idle_cs", cs_n_a, 1);
    check("per_idle_busy", busy_a, 0);

    // Parameter sweep instance.
    sv0 = sv_b;
    @(negedge clock) sample_req_b = 1'b1;
    @(negedge clock) sample_req_b = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clock);
      if (sample_valid_b) begin
        ok = 1'b1;
        break;
      end
    end
    check("b_valid_seen", ok, 1);
    axis_sel_b = 3'd0;
    #1 check("b_axis0", axis_data_b, 8'hA5);
    check("b_packed", packed_out_b, 5'b10100);
    axis_sel_b = 3'd1;
    #1 check("b_axis1_zero", axis_data_b, 0);
    repeat (20) @(negedge clock);
    check("b_idle", busy_b, 0);
    check("b_cs_low", last_low_b, 100);
    check("b_valid_count", sv_b - sv0, 1);
    check("b_mosi_cmd", cmd_b, 16'h0B0E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_sensor_poller.md
Name: spi_sensor_poller

Overview:
Parametrised SPI master that autonomously polls a multi-axis SPI sensor (ADXL362-class accelerometer) using burst register reads. It can be triggered periodically or on demand. Each completed transaction updates an atomic snapshot of all axes. The snapshot is exposed through an axis-select read port, a one-cycle valid strobe, and a packed reduced-precision vector for LEDs/7-seg. It replaces the fixed 3-axis, 5-bit, free-running SPI controller and its separate clock generator: it runs on the system clock with an internal SCLK divider.

Parameters:
CLK_DIV, 12, system clocks per SCLK half-period (100 MHz / 24 = 4.17 MHz SCLK); must be >= 2
NUM_AXES, 3, axes read per burst (1..8)
AXIS_BITS, 16, bits per axis; must be a multiple of 8
OUT_BITS, 5, MSBs per axis placed on packed_out
SAMPLE_PERIOD, 100000, system clocks between periodic triggers; must be > transaction length
READ_CMD, 8'h0B, SPI read-command byte
START_ADDR, 8'h0E, first sensor register of the burst

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  enables periodic triggering
sample_req  in  1  single-cycle on-demand trigger
clear_overrun  in  1  clears overrun flag
miso  in  1  SPI data from sensor
sclk  out  1  SPI clock, mode 0
mosi  out  1  SPI data to sensor
cs_n  out  1  SPI chip select, active low
busy  out  1  transaction in progress
sample_valid  out  1  one-cycle pulse: snapshot updated
axis_sel  in  3  snapshot axis index
axis_data  out  AXIS_BITS  snapshot[axis_sel], combinational
packed_out  out  NUM_AXES*OUT_BITS  top OUT_BITS of each axis; axis 0 in the most-significant field
overrun  out  1  sticky: a trigger arrived while busy

Behaviour:
- Reset (async): cs_n=1, sclk=0, mosi=0, busy=0, sample_valid=0, overrun=0, snapshot all 0, period counter 0, FSM=IDLE. Reset mid-transaction aborts the transaction immediately: cs_n rises and the snapshot is not updated.
- Trigger: sample_req=1, or period counter reaching SAMPLE_PERIOD-1 while enable=1. The period counter free-runs only while enable=1, wraps to 0 at SAMPLE_PERIOD-1, and holds at 0 while enable=0.
- Simultaneous periodic and request triggers count as one transaction.
- A trigger while busy=1 is dropped and sets overrun. overrun clears on clear_overrun=1, unless a new overrun occurs in the same cycle, which wins.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GUARD -> IDLE.
  - IDLE: on trigger -> SETUP. Next cycle: cs_n=0, busy=1.
  - SETUP: CLK_DIV cycles, sclk low. mosi = bit 7 of READ_CMD.
  - SHIFT: NBITS = 16 + NUM_AXES*AXIS_BITS bits, each 2*CLK_DIV cycles (sclk low half, then high half).
    - miso is sampled in the cycle sclk rises.
    - mosi updates when sclk falls.
    - Order on mosi: READ_CMD, then START_ADDR, both MSB first, then 0s.
  - HOLD: CLK_DIV cycles, sclk low, cs_n low.
  - GUARD: cs_n=1, busy=1 for CLK_DIV cycles, then IDLE.
- sample_valid pulses in the first GUARD cycle; the snapshot updates in that same cycle. axis_data and packed_out change only then, never mid-burst.
- Data byte order: bytes arrive little-endian per axis; axis k = {byte(2k+1), byte(2k)} for AXIS_BITS=16. In general, axis k takes its AXIS_BITS/8 bytes with the lowest-addressed byte least significant.
- Timing: cs_n is low for CLK_DIV*(2 + 2*NBITS) cycles; defaults give 1560 cycles.
- axis_sel >= NUM_AXES drives axis_data = 0.

Decomposition:
- Shared package spi_pkg holds: SPI FSM state enum, ADXL362 constants (READ_CMD 0x0B, WRITE_CMD 0x0A, XDATA_L 0x0E, POWER_CTL 0x2D), and the NBITS/latency calc function.
- One sub-module, spi_clk_div: a CLK_DIV half-period counter emitting single-cycle rise_tick/fall_tick. Gated by the FSM.

Test Plan:
- Reset check: assert reset mid-burst (cycle 500 after trigger) -> cs_n=1 and sclk=0 the same cycle; busy=0; snapshot unchanged at 0; no sample_valid.
- Single request, defaults, sensor model returns 0x34,0x12,0x78,0x56,0xBC,0x9A:
  - mosi carries 0x0B then 0x0E.
  - cs_n low exactly 1560 cycles.
  - sample_valid pulses once.
  - axis_sel 0/1/2 -> 0x1234/0x5678/0x9ABC.
  - packed_out = 15'b00010_01010_10011.
- Periodic mode with SAMPLE_PERIOD=5000, enable=1 for 20000 cycles -> exactly 4 transactions, starts 5000 cycles apart. Deassert enable -> no further cs_n activity.
- Overrun: sample_req at cycle 100 of an active burst -> ignored (one transaction only); overrun=1 until a clear_overrun pulse, then 0.
- Parameter sweep NUM_AXES=1, AXIS_BITS=8, CLK_DIV=2, miso byte 0xA5 -> axis_data=0xA5, packed_out=5'b10100, cs_n low 2*(2+2*24)=100 cycles.
- axis_sel=5 with defaults -> axis_data=0.
